// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// The controller imports the state enum, the default width and the counter-width helper from here.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // A bit counter that only has to reach w-1 needs $clog2(w) bits, never fewer than one.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand and result handshakes of serial_add_ctrl.
// The ovf signal exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = serial_add_pkg::DEFAULT_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy, ovf
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy, ovf
  );
`else
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );
`endif

endinterface

// File: rtl/serial_add_ctrl_fa_bit.sv
// One-bit combinational full adder.
// serial_add_ctrl instantiates it once and reuses it for every bit position.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: accepts a, b and cin, adds LSB-first through one full-adder cell and returns {cout,sum}.
// Defining SERIAL_ADD_OVF_EN adds the registered signed-overflow output ovf.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif
  logic             fa_sum;
  logic             fa_cout;

  fa_bit u_fa (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (c_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          c_d     = bus.cin;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      SHIFT: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        sum_d = {fa_sum, sum_q[WIDTH-1:1]};
        c_d   = fa_cout;
        if (cnt_q == CNT_LAST) begin
          // Wrap to zero instead of incrementing past WIDTH-1.
          cnt_d   = '0;
          state_d = DONE;
`ifdef SERIAL_ADD_OVF_EN
          // c_q is the carry into the MSB, fa_cout the carry out of it.
          ovf_d   = c_q ^ fa_cout;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake outputs follow the next state, so they are registered and never see in_valid/out_ready combinationally.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sa_q        <= '0;
      sb_q        <= '0;
      sum_q       <= '0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      sum_q       <= sum_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = c_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: accepted operands push an arithmetic expectation, a monitor checks each result.
// Build with SERIAL_ADD_OVF_EN defined to also check the ovf output.
module tb_serial_add_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   txn = 0;
  int   or_mode = 1;   // 0: out_ready low, 1: high, 2: random per cycle
  logic rnd_bit = 1'b0;
  exp_t exp_q[$];

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.out_ready = (or_mode == 2) ? rnd_bit : (or_mode == 1);

  always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow as out-of-range signed sum.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input int acc);
    exp_t   m;
    longint u;
    longint s;
    longint smax;
    u = longint'(x) + longint'(y) + longint'(ci);
    s = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
    smax = (longint'(1) << (W - 1)) - 1;
    m.sum  = u[W-1:0];
    m.cout = u[W];
    m.ovf  = (s > smax) || (s < -smax - 1);
    m.acc  = acc;
    return m;
  endfunction

  always @(posedge clk) begin
    if (rst_n && bus.in_valid && bus.in_ready)
      exp_q.push_back(model(bus.a, bus.b, bus.cin, cyc + 1));
  end

  // Monitor: pops on each rising out_valid, then checks the result stays stable while stalled.
  initial begin
    exp_t cur;
    logic prev_ov = 1'b0;
    logic have = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0;
        have = 1'b0;
      end else begin
        if (bus.out_valid && !prev_ov) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 64'(bus.sum), 64'hDEAD);
            have = 1'b0;
          end else begin
            cur = exp_q.pop_front();
            have = 1'b1;
            txn++;
            chk("sum", 64'(bus.sum), 64'(cur.sum));
            chk("cout", 64'(bus.cout), 64'(cur.cout));
`ifdef SERIAL_ADD_OVF_EN
            chk("ovf", 64'(bus.ovf), 64'(cur.ovf));
`endif
            chk("latency", 64'(cyc - cur.acc), 64'(W));
            $display("txn %0d: sum=0x%02h cout=%0b latency=%0d", txn, bus.sum, bus.cout, cyc - cur.acc);
          end
        end else if (bus.out_valid && have) begin
          chk("sum_hold", 64'(bus.sum), 64'(cur.sum));
          chk("cout_hold", 64'(bus.cout), 64'(cur.cout));
          chk("in_ready_while_done", 64'(bus.in_ready), 64'd0);
        end
        prev_ov = bus.out_valid;
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_sum"}, 64'(bus.sum), 64'd0);
    chk({tag, "_cout"}, 64'(bus.cout), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, "_ovf"}, 64'(bus.ovf), 64'd0);
`endif
  endtask

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    if (bus.in_ready) begin
      bus.a = ta;
      bus.b = tb_v;
      bus.cin = tc;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_timeout", 64'(bus.out_valid), 64'd1);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    or_mode = 1;
    repeat (3) @(negedge clk);
    chk_reset_vals("during_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", 64'(bus.in_ready), 64'd1);
    chk("post_reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("post_reset_busy", 64'(bus.busy), 64'd0);
    chk("post_reset_sum", 64'(bus.sum), 64'd0);
    chk("post_reset_cout", 64'(bus.cout), 64'd0);

    // Basic add, out_ready already high.
    issue(8'h3C, 8'h25, 1'b0);
    chk("busy_in_shift", 64'(bus.busy), 64'd1);
    wait_out_valid();
    chk("basic_sum", 64'(bus.sum), 64'h61);
    @(negedge clk);
    chk("basic_out_valid_drop", 64'(bus.out_valid), 64'd0);
    chk("basic_in_ready_back", 64'(bus.in_ready), 64'd1);

    // Carry ripples through every bit.
    issue(8'hFF, 8'h00, 1'b1);
    wait_out_valid();
    chk("chain_sum", 64'(bus.sum), 64'h00);
    chk("chain_cout", 64'(bus.cout), 64'd1);
    @(negedge clk);
`ifdef SERIAL_ADD_OVF_EN
    issue(8'h7F, 8'h01, 1'b0);
    wait_out_valid();
    chk("ovf_sum", 64'(bus.sum), 64'h80);
    chk("ovf_flag", 64'(bus.ovf), 64'd1);
    @(negedge clk);
`endif

    // Back-pressure with ignored in_valid pulses.
    or_mode = 0;
    issue(8'h5A, 8'hC3, 1'b1);
    wait_out_valid();
    for (int i = 0; i < 5; i++) begin
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0;
    or_mode = 1;
    @(negedge clk);
    chk("bp_released_in_ready", 64'(bus.in_ready), 64'd1);

    // Reset in the middle of SHIFT discards the result.
    issue(8'hAA, 8'h55, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(8'h01, 8'h01, 1'b0);
    wait_out_valid();
    chk("after_reset_sum", 64'(bus.sum), 64'h02);
    @(negedge clk);

    // Random regression with random out_ready stalls.
    or_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      issue(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    or_mode = 1;
    for (int n = 0; n < 200 && (exp_q.size() != 0 || !bus.in_ready); n++) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    chk("final_idle", 64'(bus.in_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller: accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake and adds them LSB-first, one bit per clock, through a single one-bit full-adder cell with a registered carry. It presents the WIDTH-bit sum and carry-out over a second valid/ready handshake. It drives and consumes the one-bit full-adder stage, trading WIDTH cycles of latency for a single adder cell.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 2..32
- clk  input  1  rising-edge clock, the only clock
- rst_n  input  1  reset, asynchronous assert, active-low; the only reset
- in_valid  input  1  operands a, b, cin are valid
- in_ready  output  1  block can accept operands; high only in IDLE
- a  input  WIDTH  operand A, unsigned or two's complement
- b  input  WIDTH  operand B
- cin  input  1  carry-in to bit 0
- out_valid  output  1  sum, cout (and ovf) are valid; high only in DONE
- out_ready  input  1  downstream accepts the result
- sum  output  WIDTH  result register
- cout  output  1  carry out of bit WIDTH-1
- busy  output  1  state != IDLE
- ovf  output  1  signed overflow; present only with SERIAL_ADD_OVF_EN

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid at a clock edge, the block accepts the operands:
  - a and b load into shift registers sa and sb.
  - Carry register c takes cin.
  - Bit counter cnt takes 0.
  - State moves to SHIFT.
- SHIFT: the full-adder cell sees sa[0], sb[0] and c. Each edge:
  - sa and sb shift right by one; zero fills the MSB.
  - The adder sum bit shifts into sum[WIDTH-1] while sum shifts right.
  - c takes the adder carry.
  - cnt increments.
  - When cnt==WIDTH-1, state moves to DONE on the same edge.
- DONE: out_valid=1. sum and cout=c are stable. On out_ready at an edge, state moves to IDLE.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
- cnt is $clog2(WIDTH) bits wide and never exceeds WIDTH-1.
- in_valid is ignored while state != IDLE; no operand is queued.
- out_ready is ignored outside DONE.
- sum changes during SHIFT. Its value is defined only while out_valid=1. In IDLE it holds the last result.
- Reset values: in_ready=0 during reset and 1 after; out_valid=0; busy=0; sum=0; cout=0; ovf=0; state=IDLE.
- Reset asserted mid-SHIFT or mid-DONE aborts immediately to IDLE with the reset values above. The pending result is discarded.

## Timing
- Acceptance edge E0 → SHIFT cycles at edges E1..E(WIDTH).
- out_valid rises after edge E(WIDTH), i.e. WIDTH cycles after acceptance.
- If out_ready is already high, the result is consumed at E(WIDTH+1) and in_ready returns after that edge.
- Minimum initiation interval is WIDTH+2 cycles. The block does not accept new operands in the cycle the result is consumed.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid or out_ready to any output.

## Configuration
- SERIAL_ADD_OVF_EN defined:
  - Port ovf exists.
  - At the final SHIFT edge (cnt==WIDTH-1), ovf takes (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
  - ovf is held through DONE and cleared on acceptance of new operands.
- SERIAL_ADD_OVF_EN undefined: port ovf and its register are absent. Behaviour is otherwise identical.

## Structure
- Package serial_add_pkg contains:
  - the state enum (IDLE, SHIFT, DONE);
  - the default WIDTH constant;
  - the counter-width function.
- One sub-module, fa_bit: purely combinational one-bit full adder with inputs a, b, cin and outputs sum, cout. It is instantiated once. All sequencing lives in serial_add_ctrl.

## Test plan
- Reset, WIDTH=8: after rst_n deassert → in_ready=1, out_valid=0, busy=0, sum=0x00, cout=0.
- Basic add: a=0x3C, b=0x25, cin=0, out_ready=1 → out_valid exactly 8 cycles after acceptance; sum=0x61, cout=0; in_ready high one cycle later.
- Carry chain: a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1. With SERIAL_ADD_OVF_EN: a=0x7F, b=0x01, cin=0 → sum=0x80, ovf=1.
- Back-pressure: out_ready=0 for 5 cycles after out_valid → sum and cout held stable, in_ready=0 throughout; in_valid pulses with other operands are ignored.
- Reset mid-operation: rst_n low at SHIFT cycle 4 → all outputs at reset values immediately. A fresh add a=0x01, b=0x01 then yields sum=0x02.
- Random regression: 1000 random a, b, cin with random out_ready stalls → {cout,sum} matches a+b+cin; latency is always 8 cycles to out_valid.
